// File: rtl/alu181_nibble_seq.sv
// Sequencer that runs a 4*NIBBLES-bit operation through one external 4-bit 74181-style ALU, LSB nibble first.
// Optional macro ALU181_SETTLE_EN splits each nibble into DRIVE and SAMPLE cycles for a slow or registered ALU path.
module alu181_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_A,
    input  logic [4*NIBBLES-1:0] op_B,
    input  logic [3:0]           op_S,
    input  logic                 op_M,
    input  logic                 op_CN,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 zero,
    output logic [3:0]           alu_A,
    output logic [3:0]           alu_B,
    output logic [3:0]           alu_S,
    output logic                 alu_M,
    output logic                 alu_CN,
    input  logic [3:0]           alu_F,
    input  logic                 alu_CN4
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [3:0]       s_q, s_d;
    logic             m_q, m_d;
    logic             cn_q, cn_d;
    logic [W-1:0]     result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             capture;

`ifdef ALU181_SETTLE_EN
    // phase_q=0 is DRIVE, phase_q=1 is SAMPLE; the ALU outputs are captured only on the SAMPLE edge.
    logic phase_q, phase_d;

    always_comb begin
        phase_d = 1'b0;
        if (state_q == ST_RUN) phase_d = ~phase_q;
    end

    always_ff @(posedge clk) begin
        if (rst) phase_q <= 1'b0;
        else     phase_q <= phase_d;
    end

    assign capture = phase_q;
`else
    assign capture = 1'b1;
`endif

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        m_d      = m_q;
        cn_d     = cn_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = op_A;
                    b_d     = op_B;
                    s_d     = op_S;
                    m_d     = op_M;
                    cn_d    = op_CN;
                    carry_d = op_CN;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (capture) begin
                    result_d[idx_q*4 +: 4] = alu_F;
                    // Only add and subtract chain; other arithmetic codes restart each nibble from op_CN.
                    if (!m_q) begin
                        if (s_q == S_ADD)      carry_d = ~alu_CN4;
                        else if (s_q == S_SUB) carry_d = alu_CN4;
                        else                   carry_d = cn_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        cout_d  = m_q ? 1'b0 : alu_CN4;
                        zero_d  = (result_d == '0);
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b1;
            cn_q     <= 1'b1;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            m_q      <= m_d;
            cn_q     <= cn_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;

    // Outside RUN the ALU bus sits at its reset values.
    always_comb begin
        alu_A  = 4'h0;
        alu_B  = 4'h0;
        alu_S  = 4'h0;
        alu_M  = 1'b1;
        alu_CN = 1'b1;
        if (state_q == ST_RUN) begin
            alu_A  = a_q[idx_q*4 +: 4];
            alu_B  = b_q[idx_q*4 +: 4];
            alu_S  = s_q;
            alu_M  = m_q;
            alu_CN = carry_q;
        end
    end

endmodule

// File: tb/tb_alu181_nibble_seq.sv
// Self-checking bench: a behavioural 4-bit ALU slice drives the sequencer, results are compared
// against wide-word arithmetic computed directly from the operands.
module tb_alu181_nibble_seq;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;
`ifdef ALU181_SETTLE_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_A, op_B;
    logic [3:0]   op_S;
    logic         op_M, op_CN;
    logic         busy, done, cout, zero;
    logic [W-1:0] result;
    logic [3:0]   alu_A, alu_B, alu_S, alu_F;
    logic         alu_M, alu_CN, alu_CN4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu181_nibble_seq #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .rst(rst), .start(start),
        .op_A(op_A), .op_B(op_B), .op_S(op_S), .op_M(op_M), .op_CN(op_CN),
        .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
        .alu_A(alu_A), .alu_B(alu_B), .alu_S(alu_S), .alu_M(alu_M), .alu_CN(alu_CN),
        .alu_F(alu_F), .alu_CN4(alu_CN4)
    );

    function automatic logic [W-1:0] logic_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [3:0] s);
        case (s)
            4'd0:    return ~a;
            4'd1:    return ~(a | b);
            4'd2:    return ~a & b;
            4'd3:    return '0;
            4'd4:    return ~(a & b);
            4'd5:    return ~b;
            4'd6:    return a ^ b;
            4'd7:    return a & ~b;
            4'd8:    return ~a | b;
            4'd9:    return ~(a ^ b);
            4'd10:   return b;
            4'd11:   return a & b;
            4'd12:   return '1;
            4'd13:   return a | ~b;
            4'd14:   return a | b;
            default: return a;
        endcase
    endfunction

    // External ALU slice: returns {CN4, F}; CN4 high means carry-out (add) or borrow (subtract).
    function automatic logic [4:0] alu181(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                                          input logic m, input logic cn);
        logic [4:0]   t;
        logic [W-1:0] lw;
        if (m) begin
            lw = logic_fn(W'(a), W'(b), s);
            t  = {a[0] ^ b[3], lw[3:0]};
        end else if (s == 4'b1001) begin
            t = {1'b0, a} + {1'b0, b} + 5'(!cn);
        end else if (s == 4'b0110) begin
            t[3:0] = a - b - 4'(cn);
            t[4]   = ({1'b0, a} < {1'b0, b} + 5'(cn));
        end else begin
            t = {1'b0, a} + 5'(!cn);
        end
        return t;
    endfunction

    always_comb {alu_CN4, alu_F} = alu181(alu_A, alu_B, alu_S, alu_M, alu_CN);

    // Reference: {cout, result} of the whole wide operation.
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] s, input logic m, input logic cn);
        logic [W:0] r;
        if (m) begin
            r = {1'b0, logic_fn(a, b, s)};
        end else if (s == 4'b1001) begin
            r = {1'b0, a} + {1'b0, b} + (W+1)'(!cn);
        end else if (s == 4'b0110) begin
            r[W-1:0] = a - b - W'(cn);
            r[W]     = ({1'b0, a} < {1'b0, b} + (W+1)'(cn));
        end else begin
            for (int n = 0; n < NIBBLES; n++) r[4*n +: 4] = a[4*n +: 4] + 4'(!cn);
            r[W] = (a[W-1 -: 4] == 4'hF) && !cn;
        end
        return r;
    endfunction

    // Expected active-low carry (or borrow) presented to nibble n.
    function automatic logic exp_cn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                                    input logic m, input logic cn, input int n);
        int unsigned mask, lo;
        if (n == 0 || m || (s != 4'b1001 && s != 4'b0110)) return cn;
        mask = (32'd1 << (4 * n)) - 32'd1;
        if (s == 4'b1001) begin
            lo = (32'(a) & mask) + (32'(b) & mask) + 32'(!cn);
            return !lo[4*n];
        end
        return (32'(a) & mask) < ((32'(b) & mask) + 32'(cn));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] s, input logic m, input logic cn, input bit spam);
        logic [W:0] exp;
        logic       cn_log[$];
        int         edges;
        bit         seen;
        exp = ref_op(a, b, s, m, cn);
        @(negedge clk);
        op_A = a; op_B = b; op_S = s; op_M = m; op_CN = cn; start = 1'b1;
        @(posedge clk); #1;
        if (!spam) start = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        edges = 0;
        seen  = 0;
        for (int k = 0; k < 4 * NIBBLES + 8; k++) begin
            if (done) begin
                seen = 1;
                break;
            end
            cn_log.push_back(alu_CN);
            if (spam) begin
                op_A = W'($urandom); op_B = W'($urandom);
                op_S = 4'($urandom); op_M = 1'($urandom); op_CN = 1'($urandom);
            end
            @(posedge clk); #1;
            edges++;
        end
        check({tag, ".done_seen"}, 32'(seen), 32'd1);
        check({tag, ".latency"}, 32'(edges), 32'(STEP * NIBBLES));
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        check({tag, ".result"}, 32'(result), 32'(exp[W-1:0]));
        check({tag, ".cout"}, 32'(cout), 32'(exp[W]));
        check({tag, ".zero"}, 32'(zero), 32'(exp[W-1:0] == '0));
        for (int n = 0; n < NIBBLES; n++)
            if (n * STEP < cn_log.size())
                check($sformatf("%s.alu_cn%0d", tag, n), 32'(cn_log[n*STEP]), 32'(exp_cn(a, b, s, m, cn, n)));
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".held"}, 32'(result), 32'(exp[W-1:0]));
    endtask

    initial begin
        bit saw_done;
        int kind;
        logic [3:0] s;
        rst = 1'b1; start = 1'b0;
        op_A = '0; op_B = '0; op_S = '0; op_M = 1'b0; op_CN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.result", 32'(result), 32'd0);
        check("rst.cout", 32'(cout), 32'd0);
        check("rst.zero", 32'(zero), 32'd0);
        check("rst.alu_bus", {19'd0, alu_A, alu_B, alu_S, alu_M}, {19'd0, 12'h000, 1'b1});
        check("rst.alu_cn", 32'(alu_CN), 32'd1);
        rst = 1'b0;

        run_op("add", 16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b1, 0);
        run_op("add_ovf", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 0);
        run_op("sub", 16'h1000, 16'h0001, 4'b0110, 1'b0, 1'b0, 0);
        run_op("sub_borrow", 16'h0000, 16'h0001, 4'b0110, 1'b0, 1'b0, 0);
        run_op("xor", 16'hA5A5, 16'h0FF0, 4'b0110, 1'b1, 1'b0, 0);
        run_op("spam", 16'h7A31, 16'h19C4, 4'b1001, 1'b0, 1'b1, 1);
        check("idle.alu_m", 32'(alu_M), 32'd1);

        // Reset on the 2nd RUN cycle aborts the op with no done pulse.
        @(negedge clk);
        op_A = 16'h4444; op_B = 16'h1111; op_S = 4'b1001; op_M = 1'b0; op_CN = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.result", 32'(result), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        saw_done = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) saw_done = 1;
        end
        check("abort.no_done", 32'(saw_done), 32'd0);
        run_op("after_abort", 16'h4444, 16'h1111, 4'b1001, 1'b0, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0:       s = 4'b1001;
                1:       s = 4'b0110;
                2:       s = 4'($urandom);
                default: s = 4'b0000;
            endcase
            run_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom), s, (kind == 2), 1'($urandom),
                   ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
